instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/id_pkg.sv | 24 ++
 rtl/if_fifo.sv | 65 ++++++
 rtl/instruction_fetch.sv | 128 ++++++++++++
 tb/tb_instruction_fetch.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared instruction-decode types: CPU opcode set and the fetch FSM state encoding.
package id_pkg;

  typedef enum logic [3:0] {
    NOP  = 4'h0,
    LDI  = 4'h1,
    MOV  = 4'h2,
    ADD  = 4'h3,
    SUB  = 4'h4,
    JMP  = 4'h5,
    BRZ  = 4'h6,
    HALT = 4'hF
  } cpu_instructions;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } if_state_t;

  localparam int IF_FIFO_DEPTH = 2;

endpackage

// File: rtl/if_fifo.sv
// Two-entry fetch buffer holding instruction words with their addresses.
// clear empties the buffer synchronously; push alongside pop is accepted when full.
module if_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int PC_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [PC_WIDTH-1:0]   push_pc,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [PC_WIDTH-1:0]   head_pc,
  output logic                  full,
  output logic                  empty,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] data_mem [2];
  logic [PC_WIDTH-1:0]   pc_mem   [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // When full, the write slot is the head being popped this same edge.
      if (do_push) begin
        data_mem[wr_ptr] <= push_data;
        pc_mem[wr_ptr]   <= push_pc;
        wr_ptr           <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = empty ? '0 : data_mem[rd_ptr];
  assign head_pc   = empty ? '0 : pc_mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: streams program memory 0..prog_last into a 2-entry buffer for the decoder.
// Optional IF_NOP_SKIP_EN: drop NOP words instead of forwarding them.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads while buffer credit is available
// DRAIN | last read issued, waiting for buffer to empty
// DONE  | run complete, done held until next start
module instruction_fetch
  import id_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int PC_WIDTH          = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [PC_WIDTH-1:0]          prog_last,
  output logic [PC_WIDTH-1:0]          PMEM_addr,
  output logic                         PMEM_re,
  input  logic [INSTRUCTION_WIDTH-1:0] PMEM_rdata,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [PC_WIDTH-1:0]          instr_pc,
  output logic                         busy,
  output logic                         done
);

  if_state_t           state;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] last_pc;
  logic [PC_WIDTH-1:0] inflight_pc;
  logic                inflight;
  logic                fifo_empty;
  logic                fifo_full;
  logic [1:0]          fifo_count;
  logic [2:0]          used;
  logic                pop;
  logic                push;
  logic                nop_hit;
  logic                issue;

`ifdef IF_NOP_SKIP_EN
  assign nop_hit = (PMEM_rdata[3:0] == NOP);
`else
  assign nop_hit = 1'b0;
`endif

  assign instr_valid = !fifo_empty;
  assign pop         = instr_valid && instr_ready;
  assign push        = inflight && !nop_hit;
  assign used        = {1'b0, fifo_count} + {2'b00, inflight};
  // A pop this cycle frees a slot, which sustains one read per cycle.
  assign issue       = (state == RUN) && !rst && !abort &&
                       ((used < 3'd2) || (pop && used == 3'd2));
  assign PMEM_re     = issue;
  assign PMEM_addr   = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= '0;
      last_pc     <= '0;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (abort) begin
      state    <= IDLE;
      inflight <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      inflight    <= issue;
      inflight_pc <= fetch_pc;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            fetch_pc <= '0;
            last_pc  <= prog_last;
            done     <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          // Hold the PC at the last address so a full address space never wraps.
          if (issue) begin
            if (fetch_pc == last_pc) state <= DRAIN;
            else                     fetch_pc <= fetch_pc + 1'b1;
          end
        end
        DRAIN: begin
          if (fifo_empty && !inflight) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  if_fifo #(
    .DATA_WIDTH(INSTRUCTION_WIDTH),
    .PC_WIDTH  (PC_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (abort),
    .push     (push),
    .push_data(PMEM_rdata),
    .push_pc  (inflight_pc),
    .pop      (pop),
    .head_data(instruction),
    .head_pc  (instr_pc),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  logic unused_ok;
  assign unused_ok = fifo_full;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a 1-cycle-latency program memory model.
module tb_instruction_fetch;
  import id_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, abort, instr_ready;
  logic [7:0]  prog_last;
  logic [7:0]  PMEM_addr;
  logic        PMEM_re;
  logic [15:0] PMEM_rdata;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [7:0]  instr_pc;
  logic        busy, done;

  int checks = 0;
  int failures = 0;

  logic [15:0] pmem [256];
  logic [23:0] xq [$];
  logic [7:0]  rq [$];
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .prog_last(prog_last),
    .PMEM_addr(PMEM_addr), .PMEM_re(PMEM_re), .PMEM_rdata(PMEM_rdata),
    .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_pc(instr_pc), .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    if (PMEM_re) PMEM_rdata <= pmem[PMEM_addr];
    else         PMEM_rdata <= 16'hDEAD;
  end

  always @(negedge clk) begin
    if (instr_valid && instr_ready) xq.push_back({instr_pc, instruction});
    if (PMEM_re) rq.push_back(PMEM_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_done(input string tag, input int bound);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check(tag, done, 1);
  endtask

  task automatic pulse_start(input logic [7:0] last);
    prog_last = last;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic verify_xfers(input string tag);
    int n;
    check($sformatf("%s_count", tag), xq.size(), exp_q.size());
    n = (xq.size() < exp_q.size()) ? xq.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_pc%0d", tag, i), xq[i][23:16], exp_q[i]);
      check($sformatf("%s_data%0d", tag, i), xq[i][15:0], pmem[exp_q[i]]);
    end
  endtask

  int exp_re    [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
  int exp_valid [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
  int exp_pc    [8] = '{0, 0, 0, 1, 2, 3, 0, 0};
  int exp_done  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
  int exp_busy  [8] = '{1, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    int bad;
    for (int i = 0; i < 256; i++) pmem[i] = 16'(i * 309 + 7) | 16'h0001;
    rst = 1'b1; start = 1'b0; abort = 1'b0; instr_ready = 1'b1; prog_last = 8'd0;
    tick();
    tick();
    check("rst_re", PMEM_re, 0);
    check("rst_addr", PMEM_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instruction, 0);
    check("rst_pc", instr_pc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // Basic run, ready always high: per-cycle timing table.
    xq.delete();
    pulse_start(8'd3);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t1_re_c%0d", k + 1), PMEM_re, exp_re[k]);
      if (exp_re[k] == 1) check($sformatf("t1_addr_c%0d", k + 1), PMEM_addr, k);
      check($sformatf("t1_valid_c%0d", k + 1), instr_valid, exp_valid[k]);
      if (exp_valid[k] == 1) begin
        check($sformatf("t1_pc_c%0d", k + 1), instr_pc, exp_pc[k]);
        check($sformatf("t1_instr_c%0d", k + 1), instruction, pmem[exp_pc[k]]);
      end
      check($sformatf("t1_done_c%0d", k + 1), done, exp_done[k]);
      check($sformatf("t1_busy_c%0d", k + 1), busy, exp_busy[k]);
      tick();
    end
    exp_q = '{0, 1, 2, 3};
    verify_xfers("t1");

    // Backpressure cycles 4-8; a stray start mid-run must be ignored.
    xq.delete();
    pulse_start(8'd5);
    for (int k = 1; k <= 8; k++) begin
      instr_ready = !(k >= 4 && k <= 8);
      start = (k == 6);
      #1;
      if (k >= 4) begin
        check($sformatf("t2_re_c%0d", k), PMEM_re, 0);
        check($sformatf("t2_valid_c%0d", k), instr_valid, 1);
        check($sformatf("t2_pc_c%0d", k), instr_pc, 1);
        check($sformatf("t2_instr_c%0d", k), instruction, pmem[1]);
      end
      tick();
    end
    start = 1'b0;
    instr_ready = 1'b1;
    run_to_done("t2_done", 60);
    exp_q = '{0, 1, 2, 3, 4, 5};
    verify_xfers("t2");

    // Abort with a word buffered and a read returning in the abort cycle.
    xq.delete();
    instr_ready = 1'b0;
    pulse_start(8'd10);
    tick();
    tick();
    check("t3_pre_valid", instr_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_valid", instr_valid, 0);
    check("t3_busy", busy, 0);
    check("t3_done", done, 0);
    check("t3_re", PMEM_re, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t3_stale_c%0d", k), instr_valid, 0);
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("t3_sa_busy", busy, 0);
    check("t3_sa_re", PMEM_re, 0);
    instr_ready = 1'b1;
    tick();

    // Full address space: no wrap to 0.
    xq.delete();
    rq.delete();
    pulse_start(8'd255);
    run_to_done("t4_done", 400);
    for (int k = 0; k < 4; k++) tick();
    check("t4_reads", rq.size(), 256);
    bad = 0;
    for (int i = 0; i < rq.size(); i++) if (rq[i] != 8'(i)) bad++;
    check("t4_read_order", bad, 0);
    check("t4_xfers", xq.size(), 256);
    bad = 0;
    for (int i = 0; i < xq.size(); i++)
      if (xq[i] != {8'(i), pmem[i]}) bad++;
    check("t4_xfer_order", bad, 0);

    // NOP at address 1.
    pmem[1][3:0] = NOP;
    xq.delete();
    pulse_start(8'd2);
    run_to_done("t5_done", 40);
`ifdef IF_NOP_SKIP_EN
    exp_q = '{0, 2};
`else
    exp_q = '{0, 1, 2};
`endif
    verify_xfers("t5");
    pmem[1] = 16'(1 * 309 + 7) | 16'h0001;

    // Reset mid-run, then a clean run.
    pulse_start(8'd7);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_re", PMEM_re, 0);
    check("t6_addr", PMEM_addr, 0);
    check("t6_instr", instruction, 0);
    check("t6_valid", instr_valid, 0);
    check("t6_pc", instr_pc, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    tick();
    check("t6_stale", instr_valid, 0);
    xq.delete();
    pulse_start(8'd3);
    run_to_done("t6_done_after", 40);
    exp_q = '{0, 1, 2, 3};
    verify_xfers("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
